// File: rtl/msrh_pkg.sv
// Core-wide dispatch types: decoded slot, dispatch group and buffered group entry.
package msrh_pkg;

    localparam int DISP_SIZE      = 2;
    localparam int CMT_ENTRY_SIZE = 8;
    localparam int CMT_BLK_W      = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [4:0]  rd_idx;
    } disp_t;

    typedef disp_t [DISP_SIZE-1:0] disp_grp_t;

    typedef struct packed {
        logic [riscv_pkg::VADDR_W-1:1] pc_addr;
        logic [CMT_BLK_W-1:0]          cmt_id;
        disp_grp_t                     inst;
    } disp_buf_entry_t;

endpackage

// File: rtl/riscv_pkg.sv
// Architectural constants shared by the front end and the dispatch path.
package riscv_pkg;

    localparam int VADDR_W = 39;

endpackage

// File: rtl/disp_if.sv
// Dispatch handshake: a group transfers on a cycle where valid && ready; the master
// holds pc_addr/cmt_id/inst stable while valid is high and ready is low.
interface disp_if;
    import msrh_pkg::*;

    logic                          valid;
    logic [riscv_pkg::VADDR_W-1:1] pc_addr;
    logic [CMT_BLK_W-1:0]          cmt_id;
    disp_grp_t                     inst;
    logic                          ready;

    modport master (output valid, output pc_addr, output cmt_id, output inst, input ready);
    modport slave  (input valid, input pc_addr, input cmt_id, input inst, output ready);

endinterface

// File: rtl/msrh_ring_fifo.sv
// Power-of-2 ring buffer of T with push/pop/clear; the head is read straight from storage.
module msrh_ring_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int PW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output T                 o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    T                 mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Clear wins over any same-cycle push/pop; the caller gates both anyway.
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/msrh_disp_buffer.sv
// Dispatch buffer: queues decoded groups, tags them with commit-block IDs and
// throttles on ROB block credits; a flush drops the queue and rewinds IDs/credits.
module msrh_disp_buffer
    import msrh_pkg::*;
#(
    parameter int  DEPTH    = 2,
    parameter int  ROB_BLKS = CMT_ENTRY_SIZE,
    localparam int CW       = $clog2(ROB_BLKS + 1),
    localparam int CWX      = CW + 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic [riscv_pkg::VADDR_W-1:1] i_pc_addr,
    input  disp_grp_t                     i_inst,
    output logic                          o_ready,
    input  logic                          i_flush_valid,
    input  logic                          i_cmt_release,
    disp_if.master                        disp,
    output logic [CW-1:0]                 o_credit
);

    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    disp_buf_entry_t      wr_entry;
    disp_buf_entry_t      head_entry;
    logic [CMT_BLK_W-1:0] cmt_id_q, cmt_id_d;
    logic [CW-1:0]        credit_q, credit_d;
    logic [CW:0]          credit_sum;

    assign o_ready    = i_reset_n && !full && (credit_q != '0) && !i_flush_valid;
    assign push       = i_valid && o_ready;
    assign disp.valid = i_reset_n && !empty && !i_flush_valid;
    assign pop        = disp.valid && disp.ready;

    assign wr_entry.pc_addr = i_pc_addr;
    assign wr_entry.cmt_id  = cmt_id_q;
    assign wr_entry.inst    = i_inst;

    msrh_ring_fifo #(
        .DEPTH (DEPTH),
        .T     (disp_buf_entry_t)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push),
        .i_data    (wr_entry),
        .i_pop     (pop),
        .i_clear   (i_flush_valid),
        .o_head    (head_entry),
        .o_count   (count),
        .o_full    (full),
        .o_empty   (empty)
    );

    assign disp.pc_addr = head_entry.pc_addr;
    assign disp.cmt_id  = head_entry.cmt_id;
    assign disp.inst    = head_entry.inst;

    always_comb begin
        credit_sum = {1'b0, credit_q} + CWX'(i_cmt_release) - CWX'(push);
        cmt_id_d   = cmt_id_q + CMT_BLK_W'(push);
        // Flushed groups never reached the ROB: hand back their credits and IDs.
        if (i_flush_valid) begin
            credit_sum = credit_sum + CWX'(count);
            cmt_id_d   = cmt_id_q - CMT_BLK_W'(count);
        end
        credit_d = credit_sum[CW-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            credit_q <= CW'(ROB_BLKS);
            cmt_id_q <= '0;
        end else begin
            credit_q <= credit_d;
            cmt_id_q <= cmt_id_d;
        end
    end

    assign o_credit = credit_q;

    a_hold_stable : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (disp.valid && !disp.ready) |=> (i_flush_valid || (disp.valid && $stable(head_entry))));

    a_credit_overflow : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        credit_sum <= CWX'(ROB_BLKS));

    a_release_at_max : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        i_cmt_release |-> (credit_q != CW'(ROB_BLKS)));

    a_credit_underflow : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        push |-> (credit_q != '0));

endmodule

// File: tb/tb_msrh_disp_buffer.sv
// Directed/random scenarios for the dispatch buffer, checked against a cycle model and an expected queue.
module tb_msrh_disp_buffer;
    import msrh_pkg::*;

    localparam int DEPTH    = 2;
    localparam int ROB_BLKS = 4;
    localparam int CW       = $clog2(ROB_BLKS + 1);
    localparam int PC_W     = riscv_pkg::VADDR_W - 1;
    localparam int EW       = $bits(disp_buf_entry_t);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid;
    logic [PC_W:1]   i_pc_addr;
    disp_grp_t       i_inst;
    logic            o_ready;
    logic            i_flush_valid;
    logic            i_cmt_release;
    logic [CW-1:0]   o_credit;

    disp_if u_disp ();

    msrh_disp_buffer #(
        .DEPTH    (DEPTH),
        .ROB_BLKS (ROB_BLKS)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_valid       (i_valid),
        .i_pc_addr     (i_pc_addr),
        .i_inst        (i_inst),
        .o_ready       (o_ready),
        .i_flush_valid (i_flush_valid),
        .i_cmt_release (i_cmt_release),
        .disp          (u_disp),
        .o_credit      (o_credit)
    );

    always #5 clk = ~clk;

    int                   n_tests = 0;
    int                   n_fail  = 0;
    int                   m_cnt;
    int                   m_cred;
    int                   m_rob;
    logic [CMT_BLK_W-1:0] m_id;
    logic [EW-1:0]        exp_q[$];

    function automatic logic [PC_W:1] rnd_pc();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PC_W-1:0];
    endfunction

    function automatic disp_grp_t rnd_grp();
        disp_grp_t g;
        for (int s = 0; s < DISP_SIZE; s++) begin
            g[s].valid  = 1'($urandom_range(0, 1));
            g[s].inst   = $urandom;
            g[s].rd_idx = 5'($urandom_range(0, 31));
        end
        return g;
    endfunction

    // One clock: drive inputs, check handshake/credit and pops against the model, advance.
    task automatic drive(input logic v, input logic [PC_W:1] pc, input disp_grp_t g,
                         input logic rdy, input logic fl, input logic rel,
                         output logic ob_rdy, output logic ob_vld,
                         output logic [CMT_BLK_W-1:0] ob_id);
        logic            exp_rdy;
        logic            exp_vld;
        logic [EW-1:0]   got;
        disp_buf_entry_t e;
        i_valid       = v;
        i_pc_addr     = pc;
        i_inst        = g;
        u_disp.ready  = rdy;
        i_flush_valid = fl;
        i_cmt_release = rel;
        #2;
        exp_rdy = (m_cnt < DEPTH) && (m_cred != 0) && !fl;
        exp_vld = (m_cnt != 0) && !fl;
        ob_rdy  = o_ready;
        ob_vld  = u_disp.valid;
        ob_id   = u_disp.cmt_id;
        n_tests++;
        if (o_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL o_ready: got %b expected %b", o_ready, exp_rdy);
        end
        n_tests++;
        if (u_disp.valid !== exp_vld) begin
            n_fail++;
            $display("FAIL disp_valid: got %b expected %b", u_disp.valid, exp_vld);
        end
        n_tests++;
        if (o_credit !== CW'(m_cred)) begin
            n_fail++;
            $display("FAIL o_credit: got %0d expected %0d", o_credit, m_cred);
        end
        if (exp_vld && rdy) begin
            got = {u_disp.pc_addr, u_disp.cmt_id, u_disp.inst};
            n_tests++;
            if (got !== exp_q[0]) begin
                n_fail++;
                $display("FAIL head_entry: got %h expected %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
            m_cnt--;
            m_rob++;
        end
        if (v && exp_rdy) begin
            e.pc_addr = pc;
            e.cmt_id  = m_id;
            e.inst    = g;
            exp_q.push_back(e);
            m_id = m_id + 1'b1;
            m_cnt++;
            m_cred--;
        end
        if (rel) begin
            m_cred++;
            m_rob--;
        end
        if (fl) begin
            m_id   = m_id - CMT_BLK_W'(m_cnt);
            m_cred = m_cred + m_cnt;
            m_cnt  = 0;
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        int k = 0;
        while ((m_cnt != 0 || m_rob != 0) && k < 20) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0, m_rob > 0, r, vv, id);
            k++;
        end
        n_tests++;
        if (m_cnt != 0 || m_rob != 0) begin
            n_fail++;
            $display("FAIL settle_timeout: got cnt=%0d rob=%0d expected 0/0", m_cnt, m_rob);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_valid = 1'b1;
        i_pc_addr = '0;
        i_inst = '0;
        u_disp.ready = 1'b1;
        i_flush_valid = 1'b0;
        i_cmt_release = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (o_ready !== 1'b0 || u_disp.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gating: got ready=%b valid=%b expected 0/0", o_ready, u_disp.valid);
        end
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (o_ready !== 1'b1 || u_disp.valid !== 1'b0 || o_credit !== CW'(ROB_BLKS)) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b valid=%b credit=%0d expected 1/0/%0d",
                     o_ready, u_disp.valid, o_credit, ROB_BLKS);
        end
        m_cnt = 0;
        m_cred = ROB_BLKS;
        m_rob = 0;
        m_id = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_pc(), rnd_grp(), 1'b1, 1'b0, 1'b0, r, vv, id);
            n_tests++;
            if (vv !== (i != 0) || (i != 0 && id !== CMT_BLK_W'(i - 1))) begin
                n_fail++;
                $display("FAIL basic_visibility[%0d]: got valid=%b id=%0d expected valid=%b id=%0d",
                         i, vv, id, i != 0, i - 1);
            end
        end
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, r, vv, id);
        n_tests++;
        if (o_credit !== CW'(ROB_BLKS - 3)) begin
            n_fail++;
            $display("FAIL basic_credit: got %0d expected %0d", o_credit, ROB_BLKS - 3);
        end
        settle();
    endtask

    task automatic test_backpressure();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        logic [CMT_BLK_W-1:0] base;
        logic [PC_W:1] pc_a, pc_c;
        disp_grp_t g_c;
        int k;
        base = m_id;
        pc_a = rnd_pc();
        pc_c = rnd_pc();
        g_c  = rnd_grp();
        drive(1'b1, pc_a, rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, pc_c, g_c, 1'b0, 1'b0, 1'b0, r, vv, id);
            n_tests++;
            if (r !== 1'b0 || vv !== 1'b1 || id !== base || u_disp.pc_addr !== pc_a) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ready=%b valid=%b id=%0d expected 0/1/%0d",
                         i, r, vv, id, base);
            end
        end
        k = 0;
        r = 1'b0;
        while (!r && k < 4) begin
            drive(1'b1, pc_c, g_c, 1'b1, 1'b0, 1'b0, r, vv, id);
            k++;
        end
        n_tests++;
        if (k !== 2) begin
            n_fail++;
            $display("FAIL bp_third_accept: got accepted on cycle %0d expected 2", k);
        end
        settle();
    endtask

    task automatic test_credit_stall();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        logic [CMT_BLK_W-1:0] base;
        int acc = 0;
        base = m_id;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rnd_pc(), rnd_grp(), 1'b1, 1'b0, 1'b0, r, vv, id);
            if (r) acc++;
        end
        n_tests++;
        if (acc !== ROB_BLKS || o_credit !== '0) begin
            n_fail++;
            $display("FAIL credit_stall: got accepted=%0d credit=%0d expected %0d/0", acc, o_credit, ROB_BLKS);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, r, vv, id);
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b1, 1'b0, 1'b0, r, vv, id);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, r, vv, id);
        n_tests++;
        if (vv !== 1'b1 || id !== base + CMT_BLK_W'(4)) begin
            n_fail++;
            $display("FAIL credit_resume_id: got valid=%b id=%0d expected 1/%0d", vv, id, base + 4);
        end
        settle();
    endtask

    task automatic test_flush_rewind();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        logic [CMT_BLK_W-1:0] base;
        int c_before;
        base = m_id;
        repeat (2) drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        c_before = m_cred;
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, r, vv, id);
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        n_tests++;
        if (vv !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got valid=%b expected 0", vv);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, r, vv, id);
        n_tests++;
        if (vv !== 1'b1 || id !== base || o_credit !== CW'(c_before + 1)) begin
            n_fail++;
            $display("FAIL flush_rewind: got valid=%b id=%0d credit=%0d expected 1/%0d/%0d",
                     vv, id, o_credit, base, c_before + 1);
        end
        settle();
    endtask

    task automatic test_flush_release();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        int c_before;
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, r, vv, id);
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        c_before = m_cred;
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b1, 1'b1, 1'b1, r, vv, id);
        n_tests++;
        if (r !== 1'b0 || vv !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_gating: got ready=%b valid=%b expected 0/0", r, vv);
        end
        n_tests++;
        if (o_credit !== CW'(c_before + 2) || u_disp.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_release_credit: got credit=%0d valid=%b expected %0d/0",
                     o_credit, u_disp.valid, c_before + 2);
        end
        settle();
    endtask

    task automatic test_wrap();
        logic r, vv;
        logic [CMT_BLK_W-1:0] id;
        int k = 0;
        while (m_id != {CMT_BLK_W{1'b1}} - 1'b1 && k < 60) begin
            drive(m_cred > 0, rnd_pc(), rnd_grp(), 1'b1, 1'b0, m_rob > 0, r, vv, id);
            k++;
        end
        settle();
        repeat (2) drive(1'b1, rnd_pc(), rnd_grp(), 1'b1, 1'b0, 1'b0, r, vv, id);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, r, vv, id);
        repeat (2) drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, r, vv, id);
        n_tests++;
        if (vv !== 1'b1 || id !== '0) begin
            n_fail++;
            $display("FAIL wrap_head: got valid=%b id=%0d expected 1/0", vv, id);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, r, vv, id);
        drive(1'b1, rnd_pc(), rnd_grp(), 1'b0, 1'b0, 1'b0, r, vv, id);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, r, vv, id);
        n_tests++;
        if (vv !== 1'b1 || id !== '0 || o_credit !== CW'(1)) begin
            n_fail++;
            $display("FAIL wrap_flush_rewind: got valid=%b id=%0d credit=%0d expected 1/0/1", vv, id, o_credit);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_credit_stall();
        test_flush_rewind();
        test_flush_release();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
